// File: rtl/dsram_responder.sv
// Data SRAM responder: word RAM with byte strobes and a registered read-first port,
// plus an MMIO window holding the LED register, a free-running timer and a RAM-store counter.
module dsram_responder #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_en,
   input  logic [3:0]  sram_we,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic [15:0] led
);

   localparam int unsigned DEPTH     = 1 << ADDR_W;
   localparam logic [15:0] OFS_LED   = 16'h0000;
   localparam logic [15:0] OFS_TIMER = 16'h0004;
   localparam logic [15:0] OFS_SCNT  = 16'h0008;

   logic [31:0] ram_q [DEPTH];

   logic [31:0] rdata_q, rdata_d;
   logic [15:0] led_q, led_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] store_cnt_q, store_cnt_d;

   logic              is_mmio;
   logic [ADDR_W-1:0] ram_idx;
   logic [15:0]       mmio_ofs;
   logic [31:0]       wmask;
   logic              ram_wr;
   logic              mmio_wr;
   logic [31:0]       ram_word;
   logic [31:0]       mmio_word;

   always_comb begin
      is_mmio  = (sram_addr[31:16] == MMIO_BASE[31:16]);
      ram_idx  = sram_addr[ADDR_W+1:2];
      mmio_ofs = sram_addr[15:0];
      wmask    = {{8{sram_we[3]}}, {8{sram_we[2]}}, {8{sram_we[1]}}, {8{sram_we[0]}}};
      ram_wr   = sram_en && (sram_we != 4'b0000) && !is_mmio;
      mmio_wr  = sram_en && (sram_we != 4'b0000) && is_mmio;
      ram_word = ram_q[ram_idx];
      mmio_word = 32'h0;
      case (mmio_ofs)
         OFS_LED:   mmio_word = {16'h0000, led_q};
         OFS_TIMER: mmio_word = timer_q;
         OFS_SCNT:  mmio_word = store_cnt_q;
         default:   mmio_word = 32'h0;
      endcase
   end

   // All reads sample pre-edge state, so read data is always the pre-write value.
   always_comb begin
      rdata_d     = rdata_q;
      led_d       = led_q;
      timer_d     = timer_q + 32'd1;
      store_cnt_d = store_cnt_q;
      if (sram_en) begin
         rdata_d = is_mmio ? mmio_word : ram_word;
      end
      if (mmio_wr && (mmio_ofs == OFS_LED)) begin
         led_d = (sram_wdata[15:0] & wmask[15:0]) | (led_q & ~wmask[15:0]);
      end
      if (mmio_wr && (mmio_ofs == OFS_TIMER)) begin
         timer_d = (sram_wdata & wmask) | (timer_q & ~wmask);
      end
      if (ram_wr && (store_cnt_q != 32'hffff_ffff)) begin
         store_cnt_d = store_cnt_q + 32'd1;
      end
      if (reset) begin
         rdata_d     = 32'h0;
         led_d       = 16'h0;
         timer_d     = 32'h0;
         store_cnt_d = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      rdata_q     <= rdata_d;
      led_q       <= led_d;
      timer_q     <= timer_d;
      store_cnt_q <= store_cnt_d;
   end

   // RAM contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (!reset && ram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (sram_we[i]) begin
               ram_q[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
         end
      end
   end

   assign sram_rdata = rdata_q;
   assign led        = led_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: directed accesses push expected values into a scoreboard,
// and a monitor pops and compares them after each observed clock edge.
module tb_dsram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [15:0] led;

   localparam logic [31:0] A_LED   = 32'hbfaf_0000;
   localparam logic [31:0] A_TIMER = 32'hbfaf_0004;
   localparam logic [31:0] A_SCNT  = 32'hbfaf_0008;

   dsram_responder dut (
      .clk        (clk),
      .reset      (reset),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .led        (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exp;
      bit          is_led;
      string       nm;
   } exp_t;

   exp_t sb[$];
   bit   obs = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   // Monitor: obs marks that the value after this edge has a queued expectation.
   always @(posedge clk) begin
      if (obs) begin
         exp_t e;
         logic [31:0] act;
         #1;
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: monitor observed output with empty scoreboard");
         end else begin
            e   = sb.pop_front();
            act = e.is_led ? {16'h0000, led} : sram_rdata;
            if (act !== e.exp) begin
               n_err++;
               $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
            end
         end
      end
   end

   task automatic cyc(input logic r, input logic en, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit chk, input bit chk_led, input logic [31:0] exp,
                      input string nm);
      exp_t e;
      @(negedge clk);
      reset      = r;
      sram_en    = en;
      sram_we    = we;
      sram_addr  = a;
      sram_wdata = wd;
      obs        = chk;
      if (chk) begin
         e.exp    = exp;
         e.is_led = chk_led;
         e.nm     = nm;
         sb.push_back(e);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
      cyc(1'b0, 1'b1, we, a, wd, 1'b0, 1'b0, 32'h0, "");
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      cyc(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b1, 1'b0, exp, nm);
   endtask

   task automatic wr_led(input logic [31:0] wd, input logic [3:0] we,
                         input logic [31:0] exp, input string nm);
      cyc(1'b0, 1'b1, we, A_LED, wd, 1'b1, 1'b1, exp, nm);
   endtask

   // en=0 with live-looking strobes: nothing may change.
   task automatic idle(input bit chk, input logic [31:0] exp, input string nm);
      cyc(1'b0, 1'b0, 4'hf, 32'h0000_0800, 32'hffff_ffff, chk, 1'b0, exp, nm);
   endtask

   task automatic backdoor_cnt(input logic [31:0] v);
      @(negedge clk);
      sram_en = 1'b0;
      sram_we = 4'h0;
      obs     = 1'b0;
      dut.store_cnt_q = v;
   endtask

   initial begin
      reset = 1'b1; sram_en = 1'b0; sram_we = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "");
      cyc(1'b1, 1'b1, 4'hf, A_LED, 32'hffff_ffff, 1'b1, 1'b0, 32'h0, "rst_rdata");
      cyc(1'b1, 1'b1, 4'hf, A_LED, 32'hffff_ffff, 1'b1, 1'b1, 32'h0, "rst_led");

      rd(A_TIMER, 32'h0, "timer_first");
      rd(A_TIMER, 32'h1, "timer_second");

      wr(32'h1c00_0100, 32'h1122_3344, 4'hf);
      wr(32'h1c00_0100, 32'hAABB_CCDD, 4'b0101);
      rd(32'h1c00_0100, 32'h11BB_33DD, "byte_lanes");

      wr(32'h0000_0800, 32'h5, 4'hf);
      cyc(1'b0, 1'b1, 4'hf, 32'h0000_0800, 32'h9, 1'b1, 1'b0, 32'h5, "read_first");
      rd(32'h0000_0800, 32'h9, "rd_after_wr");
      for (int i = 0; i < 3; i++) idle(1'b1, 32'h9, "hold_en0");
      rd(32'h0000_0800, 32'h9, "en0_no_write");

      wr(32'h0000_0040, 32'h0000_CAFE, 4'hf);
      rd(32'h0000_4040, 32'h0000_CAFE, "alias");

      wr(32'h0000_0000, 32'h7777_7777, 4'hf);
      wr(32'h0000_0300, 32'h1111_0000, 4'hf);

      wr_led(32'hFFFF_A5A5, 4'hf, 32'h0000_A5A5, "led_wr");
      rd(A_LED, 32'h0000_A5A5, "led_rd");
      wr_led(32'h1234_0000, 4'b1100, 32'h0000_A5A5, "led_upper_ign");
      wr_led(32'h0000_3C00, 4'b0010, 32'h0000_3CA5, "led_lane1");
      wr(32'hbfaf_0010, 32'hDEAD_BEEF, 4'hf);
      rd(32'hbfaf_0010, 32'h0, "unmapped");
      rd(32'h0000_0000, 32'h7777_7777, "mmio_no_ram");

      wr(A_TIMER, 32'hFFFF_FFFE, 4'hf);
      rd(A_TIMER, 32'hFFFF_FFFE, "timer_load");
      rd(A_TIMER, 32'hFFFF_FFFF, "timer_max");
      rd(A_TIMER, 32'h0, "timer_wrap");
      wr(A_TIMER, 32'h0000_AB00, 4'b0010);
      rd(A_TIMER, 32'h0000_AB01, "timer_merge");

      cyc(1'b1, 1'b1, 4'hf, 32'h0000_0300, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, "rst_mid_rdata");
      rd(A_TIMER, 32'h0, "timer_rst");
      rd(32'h0000_0300, 32'h1111_0000, "rst_no_ram_wr");
      cyc(1'b0, 1'b1, 4'h0, A_LED, 32'h0, 1'b1, 1'b1, 32'h0, "led_rst");

      for (int i = 0; i < 5; i++) wr(32'h0000_0900 + 32'(4 * i), 32'(i), 4'hf);
      wr(A_LED, 32'h1, 4'hf);
      wr(A_SCNT, 32'h1234, 4'hf);
      cyc(1'b0, 1'b0, 4'hf, 32'h0000_0914, 32'h1, 1'b0, 1'b0, 32'h0, "");
      rd(A_SCNT, 32'h5, "store_cnt");

      backdoor_cnt(32'hFFFF_FFFE);
      wr(32'h0000_0918, 32'h1, 4'hf);
      rd(A_SCNT, 32'hFFFF_FFFF, "cnt_to_max");
      wr(32'h0000_091c, 32'h1, 4'b0001);
      rd(A_SCNT, 32'hFFFF_FFFF, "cnt_sat");

      idle(1'b0, 32'h0, "");
      idle(1'b0, 32'h0, "");
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
